// File: rtl/gc_dram_array.sv
// Behavioural gain-cell DRAM macro: each row has a retention counter, and its data is lost when the counter expires.
// Adds a non-destructive refresh port, a pipelined read with stale/conflict flags, and a registered live-row count.
module gc_dram_array #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 128,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int RETENTION = 5000,
  parameter int RD_LAT    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       re,
  input  logic [ADDR_W-1:0]          raddr,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       ref_en,
  input  logic [ADDR_W-1:0]          ref_addr,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_stale,
  output logic                       rd_conflict,
  output logic                       ref_miss,
  output logic [$clog2(DEPTH+1)-1:0] live_cnt
);

  localparam int CNT_W  = $clog2(RETENTION + 1);
  localparam int LIVE_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RETENTION);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("gc_dram_array: RD_LAT must be in 1..4");
  end
  if (RETENTION < 1) begin : g_bad_retention
    $error("gc_dram_array: RETENTION must be >= 1");
  end

  typedef struct packed {
    logic              valid;
    logic              stale;
    logic              conflict;
    logic [DATA_W-1:0] data;
  } rd_stage_t;

  logic [DATA_W-1:0] mem      [DEPTH];
  logic [CNT_W-1:0]  cnt      [DEPTH];
  logic [CNT_W-1:0]  cnt_next [DEPTH];
  logic [LIVE_W-1:0] live_next;
  logic              raddr_live;
  logic              ref_live;
  logic              rd_hit_write;
  logic              ref_miss_next;
  rd_stage_t         stage_in;
  rd_stage_t         pipe [RD_LAT];

  // Read sampling and refresh qualification, all from pre-edge row state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    stage_in      = '0;
    raddr_live    = (cnt[raddr] != '0);
    ref_live      = (cnt[ref_addr] != '0);
    rd_hit_write  = we && (waddr == raddr);
    ref_miss_next = ref_en && !ref_live && !(we && (waddr == ref_addr));
    if (re) begin
      stage_in.valid    = 1'b1;
      stage_in.stale    = !raddr_live;
      stage_in.conflict = rd_hit_write;
      stage_in.data     = (raddr_live && !rd_hit_write) ? mem[raddr] : 'x;
    end
  end

  // Per-row counter update: write beats refresh, refresh only revives a live row, dead rows stay at zero.
  always_comb begin
    live_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (we && (waddr == ADDR_W'(i))) begin
        cnt_next[i] = CNT_LOAD;
      end else if (ref_en && (ref_addr == ADDR_W'(i)) && (cnt[i] != '0)) begin
        cnt_next[i] = CNT_LOAD;
      end else if (cnt[i] != '0) begin
        cnt_next[i] = cnt[i] - CNT_W'(1);
      end else begin
        cnt_next[i] = '0;
      end
      if (cnt_next[i] != '0) live_next = live_next + LIVE_W'(1);
    end
  end

  // NOTE: the data array has no reset; liveness is tracked only by cnt, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples the same pre-edge values.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) cnt[i] <= '0;
      for (int s = 0; s < RD_LAT; s++) pipe[s] <= '0;
      ref_miss <= 1'b0;
      live_cnt <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) cnt[i] <= cnt_next[i];
      pipe[0] <= stage_in;
      for (int s = 1; s < RD_LAT; s++) pipe[s] <= pipe[s-1];
      ref_miss <= ref_miss_next;
      live_cnt <= live_next;
    end
  end

  assign rd_valid    = pipe[RD_LAT-1].valid;
  assign rd_stale    = pipe[RD_LAT-1].stale;
  assign rd_conflict = pipe[RD_LAT-1].conflict;
  assign rd_data     = pipe[RD_LAT-1].data;

endmodule

// File: tb/tb_gc_dram_array.sv
// Bench for gc_dram_array: directed scenarios plus random traffic, scored against a timestamp-based retention model.
module tb_gc_dram_array;

  localparam int DATA_W    = 16;
  localparam int DEPTH     = 16;
  localparam int ADDR_W    = 4;
  localparam int RETENTION = 8;
  localparam int RD_LAT    = 2;
  localparam int LIVE_W    = 5;

  logic              clk = 1'b0;
  logic              rst, re, we, ref_en;
  logic [ADDR_W-1:0] raddr, waddr, ref_addr;
  logic [DATA_W-1:0] wdata;
  logic              rd_valid, rd_stale, rd_conflict, ref_miss;
  logic [DATA_W-1:0] rd_data;
  logic [LIVE_W-1:0] live_cnt;

  gc_dram_array #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RETENTION(RETENTION), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .re(re), .raddr(raddr), .we(we), .waddr(waddr), .wdata(wdata),
    .ref_en(ref_en), .ref_addr(ref_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_stale(rd_stale), .rd_conflict(rd_conflict), .ref_miss(ref_miss), .live_cnt(live_cnt)
  );

  always #5 clk = ~clk;

  // Model: a row is live at edge e iff it was last written/refreshed at edge L with e - L <= RETENTION.
  typedef struct {
    int                e;
    bit                stale;
    bit                conflict;
    logic [DATA_W-1:0] data;
  } rd_exp_t;

  rd_exp_t           exp_q [$];
  bit                has_load  [DEPTH];
  int                load_e    [DEPTH];
  logic [DATA_W-1:0] model_mem [DEPTH];
  int                edge_n   = 0;
  int                n_checks = 0;
  int                n_bad    = 0;

  function automatic bit row_live(int r, int e);
    return has_load[r] && (e - load_e[r] <= RETENTION);
  endfunction

  task automatic idle();
    rst = 1'b0; re = 1'b0; we = 1'b0; ref_en = 1'b0;
    raddr = '0; waddr = '0; ref_addr = '0; wdata = '0;
  endtask

  // Advance one edge, update the model with the inputs sampled there, then score the DUT outputs.
  task automatic tick();
    bit      was_rst;
    bit      exp_miss;
    int      exp_live;
    rd_exp_t x;
    @(posedge clk);
    edge_n++;
    was_rst  = rst;
    exp_miss = 1'b0;
    exp_live = 0;
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) has_load[r] = 1'b0;
      exp_q.delete();
    end else begin
      if (re) begin
        x.e        = edge_n;
        x.stale    = !row_live(int'(raddr), edge_n);
        x.conflict = we && (waddr == raddr);
        x.data     = model_mem[raddr];
        exp_q.push_back(x);
      end
      exp_miss = ref_en && !row_live(int'(ref_addr), edge_n) && !(we && (waddr == ref_addr));
      if (ref_en && row_live(int'(ref_addr), edge_n)) load_e[ref_addr] = edge_n;
      if (we) begin
        has_load[waddr]  = 1'b1;
        load_e[waddr]    = edge_n;
        model_mem[waddr] = wdata;
      end
      for (int r = 0; r < DEPTH; r++)
        if (has_load[r] && (edge_n - load_e[r] < RETENTION)) exp_live++;
    end
    #1;
    n_checks++;
    if (live_cnt !== LIVE_W'(exp_live)) begin
      n_bad++; $display("FAIL sb_live_cnt edge=%0d got=%0d want=%0d", edge_n, live_cnt, exp_live);
    end
    n_checks++;
    if (ref_miss !== exp_miss) begin
      n_bad++; $display("FAIL sb_ref_miss edge=%0d got=%b want=%b", edge_n, ref_miss, exp_miss);
    end
    if (!was_rst && exp_q.size() > 0 && exp_q[0].e == edge_n - RD_LAT + 1) begin
      x = exp_q.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_stale !== x.stale || rd_conflict !== x.conflict) begin
        n_bad++;
        $display("FAIL sb_rd_flags edge=%0d got v/s/c=%b%b%b want=1%b%b",
                 edge_n, rd_valid, rd_stale, rd_conflict, x.stale, x.conflict);
      end
      if (!x.stale && !x.conflict) begin
        n_checks++;
        if (rd_data !== x.data) begin
          n_bad++; $display("FAIL sb_rd_data edge=%0d got=%h want=%h", edge_n, rd_data, x.data);
        end
      end
    end else begin
      n_checks++;
      if (rd_valid !== 1'b0 || rd_stale !== 1'b0 || rd_conflict !== 1'b0) begin
        n_bad++;
        $display("FAIL sb_rd_idle edge=%0d got v/s/c=%b%b%b want=000", edge_n, rd_valid, rd_stale, rd_conflict);
      end
      if (was_rst) begin
        n_checks++;
        if (rd_data !== '0) begin
          n_bad++; $display("FAIL sb_rst_data edge=%0d got=%h want=0", edge_n, rd_data);
        end
      end
    end
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; re = 1'b1; raddr = 4'd1; ref_en = 1'b1; ref_addr = 4'd2;
    tick();
    tick();
    n_checks++;
    if (rd_valid !== 1'b0 || ref_miss !== 1'b0 || live_cnt !== '0 || rd_data !== '0) begin
      n_bad++;
      $display("FAIL reset_state got v=%b miss=%b live=%0d data=%h want 0/0/0/0", rd_valid, ref_miss, live_cnt, rd_data);
    end
    idle();
  endtask

  task automatic test_retention();
    do_reset();
    we = 1'b1; waddr = 4'd3; wdata = 16'hA5A5;
    tick();
    idle();
    repeat (7) tick();
    n_checks++;
    if (live_cnt !== 5'd1) begin n_bad++; $display("FAIL ret_live_before got=%0d want=1", live_cnt); end
    re = 1'b1; raddr = 4'd3;
    tick();
    n_checks++;
    if (live_cnt !== 5'd0) begin n_bad++; $display("FAIL ret_live_after got=%0d want=0", live_cnt); end
    tick();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_stale !== 1'b0 || rd_data !== 16'hA5A5) begin
      n_bad++; $display("FAIL ret_last_live got v=%b s=%b d=%h want 1/0/a5a5", rd_valid, rd_stale, rd_data);
    end
    idle();
    tick();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_stale !== 1'b1) begin
      n_bad++; $display("FAIL ret_first_stale got v=%b s=%b want 1/1", rd_valid, rd_stale);
    end
    tick();
  endtask

  task automatic test_refresh();
    logic [DATA_W-1:0] v;
    v = DATA_W'($urandom);
    do_reset();
    we = 1'b1; waddr = 4'd5; wdata = v;
    tick();
    idle();
    repeat (5) tick();
    ref_en = 1'b1; ref_addr = 4'd5;
    tick();
    idle();
    repeat (7) tick();
    re = 1'b1; raddr = 4'd5;
    tick();
    tick();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_stale !== 1'b0 || rd_data !== v) begin
      n_bad++; $display("FAIL ref_extended got v=%b s=%b d=%h want 1/0/%h", rd_valid, rd_stale, rd_data, v);
    end
    idle();
    tick();
    n_checks++;
    if (rd_stale !== 1'b1) begin n_bad++; $display("FAIL ref_expired got s=%b want 1", rd_stale); end
    tick();
  endtask

  task automatic test_ref_miss();
    do_reset();
    ref_en = 1'b1; ref_addr = 4'd7;
    tick();
    idle();
    n_checks++;
    if (ref_miss !== 1'b1 || live_cnt !== '0) begin
      n_bad++; $display("FAIL ref_miss_pulse got miss=%b live=%0d want 1/0", ref_miss, live_cnt);
    end
    tick();
    n_checks++;
    if (ref_miss !== 1'b0) begin n_bad++; $display("FAIL ref_miss_clear got=%b want 0", ref_miss); end
  endtask

  task automatic test_conflict();
    do_reset();
    we = 1'b1; waddr = 4'd2; wdata = 16'h1234; re = 1'b1; raddr = 4'd2;
    tick();
    idle();
    re = 1'b1; raddr = 4'd2;
    tick();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_conflict !== 1'b1) begin
      n_bad++; $display("FAIL conflict_flag got v=%b c=%b want 1/1", rd_valid, rd_conflict);
    end
    idle();
    we = 1'b1; waddr = 4'd6; wdata = 16'h0F0F; ref_en = 1'b1; ref_addr = 4'd6;
    tick();
    n_checks++;
    if (rd_conflict !== 1'b0 || rd_stale !== 1'b0 || rd_data !== 16'h1234) begin
      n_bad++; $display("FAIL conflict_after got c=%b s=%b d=%h want 0/0/1234", rd_conflict, rd_stale, rd_data);
    end
    idle();
    n_checks++;
    if (ref_miss !== 1'b0 || live_cnt !== 5'd2) begin
      n_bad++; $display("FAIL write_beats_ref got miss=%b live=%0d want 0/2", ref_miss, live_cnt);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] vals [DEPTH];
    int got;
    int gaps;
    got  = 0;
    gaps = 0;
    for (int i = 0; i < DEPTH; i++) vals[i] = DATA_W'($urandom);
    do_reset();
    // Writes rows 0..15, then refresh keeps each row inside its window while reads sweep 0..15.
    for (int t = 0; t < 32 + RD_LAT; t++) begin
      idle();
      if (t < 16) begin we = 1'b1; waddr = ADDR_W'(t); wdata = vals[t]; end
      if (t >= 8 && t < 24) begin ref_en = 1'b1; ref_addr = ADDR_W'(t - 8); end
      if (t >= 16 && t < 32) begin re = 1'b1; raddr = ADDR_W'(t - 16); end
      tick();
      if (t == 15) begin
        n_checks++;
        if (live_cnt !== 5'd16) begin n_bad++; $display("FAIL b2b_live got=%0d want=16", live_cnt); end
      end
      if (rd_valid === 1'b1 && got < DEPTH) begin
        n_checks++;
        if (rd_data !== vals[got] || rd_stale !== 1'b0) begin
          n_bad++; $display("FAIL b2b_data row=%0d got=%h s=%b want=%h s=0", got, rd_data, rd_stale, vals[got]);
        end
        got++;
      end else if (got > 0 && got < DEPTH) begin
        gaps++;
      end
    end
    n_checks++;
    if (got !== DEPTH || gaps !== 0) begin
      n_bad++; $display("FAIL b2b_count got=%0d gaps=%0d want=16 gaps=0", got, gaps);
    end
    idle();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    we = 1'b1; waddr = 4'd3; wdata = 16'h5A5A;
    tick();
    idle();
    re = 1'b1; raddr = 4'd3;
    tick();
    idle();
    rst = 1'b1;
    tick();
    n_checks++;
    if (rd_valid !== 1'b0 || live_cnt !== '0) begin
      n_bad++; $display("FAIL rst_mid_read got v=%b live=%0d want 0/0", rd_valid, live_cnt);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_no_late_valid got=%b want 0", rd_valid); end
    re = 1'b1; raddr = 4'd3;
    tick();
    idle();
    tick();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_stale !== 1'b1) begin
      n_bad++; $display("FAIL rst_row_dead got v=%b s=%b want 1/1", rd_valid, rd_stale);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      idle();
      rst      = ($urandom_range(0, 149) == 0);
      re       = ($urandom_range(0, 1) == 1);
      we       = ($urandom_range(0, 3) == 0);
      ref_en   = ($urandom_range(0, 2) == 0);
      raddr    = ADDR_W'($urandom_range(0, 5));
      waddr    = ADDR_W'($urandom_range(0, 5));
      ref_addr = ADDR_W'($urandom_range(0, 5));
      wdata    = DATA_W'($urandom);
      tick();
    end
    idle();
    repeat (RD_LAT + 1) tick();
  endtask

  initial begin
    test_reset();
    test_retention();
    test_refresh();
    test_ref_miss();
    test_conflict();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
